// File: rtl/rbg_sched_ctrl.sv
// rbg_sched_ctrl
// Control sequencer for the beam power calculator. It follows RE position
// inside each symbol of the beam-domain stream and produces the per-RE RBG
// numbering, the slot-start clear and power-symbol flags, and the AIU index.
// The stream strobes are forwarded with the same one-cycle latency.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_cfg_*                 configuration written to the shadow set on i_cfg_vld
//   i_data_vld/sop/eop      input stream strobes, one RE per vld cycle
//   i_symb_idx              symbol index, sampled at sop
//   o_data_vld/sop/eop      registered stream strobes (overrun REs dropped)
//   o_re_num/o_rbg_num      RE index inside the RBG / RBG index inside the symbol
//   o_rbg_load              first RE of each RBG
//   o_symb_clr/o_symb_1st   slot-start pulse / power-symbol flag
//   o_aiu_idx               AIU selector, updated at sop
//   o_err_overrun/underrun  error pulses
//   o_busy                  inside a symbol
module rbg_sched_ctrl #(
  parameter int RE_PER_RB = 12,
  parameter int RBW       = 9
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_cfg_vld,
  input  logic [3:0]     i_cfg_rbg_size,
  input  logic [RBW-1:0] i_cfg_rb_total,
  input  logic [3:0]     i_cfg_pwr_symb,
  input  logic           i_cfg_aiu_idx,
  input  logic           i_data_vld,
  input  logic           i_data_sop,
  input  logic           i_data_eop,
  input  logic [3:0]     i_symb_idx,
  output logic           o_data_vld,
  output logic           o_data_sop,
  output logic           o_data_eop,
  output logic [7:0]     o_re_num,
  output logic [7:0]     o_rbg_num,
  output logic           o_rbg_load,
  output logic           o_symb_clr,
  output logic           o_symb_1st,
  output logic           o_aiu_idx,
  output logic           o_err_overrun,
  output logic           o_err_underrun,
  output logic           o_busy
);

  // Wide enough for RB_MAX * RE_PER_RB (273*12 = 3276 needs 12 bits).
  localparam int TW = RBW + $clog2(RE_PER_RB);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t state, state_nx;

  // shadow configuration
  logic [3:0]     sh_rbg_size;
  logic [RBW-1:0] sh_rb_total;
  logic [3:0]     sh_pwr_symb;
  logic           sh_aiu;

  // active configuration, loaded at each accepted sop
  logic [7:0]     act_len;
  logic [TW-1:0]  act_total;
  logic           pwr_on;

  // position of the next RE in the current symbol
  logic [7:0]     re_cnt, rbg_cnt;
  logic [TW-1:0]  tot_cnt;

  logic [3:0]     size_eff;
  logic [RBW-1:0] rb_eff;
  logic [7:0]     sh_len, cur_len, pos_re, pos_rbg, re_inc, re_nx, rbg_nx;
  logic [TW-1:0]  sh_total, cur_total, pos_tot;
  logic           sop_acc, re_acc, ovr, take, wrap;

  // registered-output next values
  logic       vld_d, sop_d, eop_d, load_d, clr_d, s1st_d, aiu_d, ovr_d, und_d, busy_d;
  logic [7:0] re_d, rbg_d;

  assign size_eff = (sh_rbg_size == 4'd0) ? 4'd1 : sh_rbg_size;
  assign rb_eff   = (sh_rb_total == '0) ? RBW'(1) : sh_rb_total;
  assign sh_len   = 8'(size_eff * RE_PER_RB);
  assign sh_total = TW'(rb_eff * RE_PER_RB);

  // A sop is honoured in ARMED and in RUN (restart on missing eop).
  assign sop_acc = i_data_vld & i_data_sop & (state != IDLE);
  assign re_acc  = i_data_vld & ~i_data_sop & (state == RUN);
  assign ovr     = re_acc & (tot_cnt >= act_total);
  assign take    = sop_acc | (re_acc & ~ovr);

  // The sop RE is numbered with the configuration it loads, so take the
  // shadow values directly on that cycle.
  assign cur_len   = sop_acc ? sh_len   : act_len;
  assign cur_total = sop_acc ? sh_total : act_total;
  assign pos_re    = sop_acc ? 8'd0 : re_cnt;
  assign pos_rbg   = sop_acc ? 8'd0 : rbg_cnt;
  assign pos_tot   = sop_acc ? '0   : tot_cnt;

  assign re_inc = pos_re + 8'd1;
  assign wrap   = (re_inc == cur_len);
  assign re_nx  = wrap ? 8'd0 : re_inc;
  assign rbg_nx = wrap ? pos_rbg + 8'd1 : pos_rbg;

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (i_cfg_vld) state_nx = ARMED;
      ARMED: if (sop_acc)   state_nx = i_data_eop ? ARMED : RUN;
      RUN:   if (i_data_vld & i_data_eop) state_nx = ARMED;
             else if (sop_acc)            state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs (next values of the output registers)
  always_comb begin
    vld_d  = take;
    sop_d  = sop_acc;
    eop_d  = take & i_data_eop;
    re_d   = take ? pos_re  : 8'd0;
    rbg_d  = take ? pos_rbg : 8'd0;
    load_d = take & (pos_re == 8'd0) & (pos_tot < cur_total);
    clr_d  = sop_acc & (i_symb_idx == 4'd0);
    s1st_d = take & (sop_acc ? (i_symb_idx == sh_pwr_symb) : pwr_on);
    aiu_d  = sop_acc ? sh_aiu : o_aiu_idx;
    ovr_d  = ovr;
    // Short symbol: either an eop that lands early, or a sop arriving in RUN
    // while the old symbol had not reached its RE total.
    und_d  = (eop_d & ((pos_tot + TW'(1)) < cur_total)) |
             (sop_acc & (state == RUN) & (tot_cnt < act_total));
    busy_d = (state_nx == RUN);
  end

  // Shadow and active configuration, position counters.
  // Active loads from the pre-edge shadow, so a cfg_vld coincident with sop
  // only takes effect on the following symbol.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh_rbg_size <= '0;
      sh_rb_total <= '0;
      sh_pwr_symb <= '0;
      sh_aiu      <= 1'b0;
      act_len     <= '0;
      act_total   <= '0;
      pwr_on      <= 1'b0;
      re_cnt      <= '0;
      rbg_cnt     <= '0;
      tot_cnt     <= '0;
    end else begin
      if (i_cfg_vld) begin
        sh_rbg_size <= i_cfg_rbg_size;
        sh_rb_total <= i_cfg_rb_total;
        sh_pwr_symb <= i_cfg_pwr_symb;
        sh_aiu      <= i_cfg_aiu_idx;
      end
      if (sop_acc) begin
        act_len   <= sh_len;
        act_total <= sh_total;
        pwr_on    <= (i_symb_idx == sh_pwr_symb);
      end
      // gaps and dropped REs leave the counters frozen
      if (take) begin
        re_cnt  <= re_nx;
        rbg_cnt <= rbg_nx;
        tot_cnt <= pos_tot + TW'(1);
      end
    end
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data_vld     <= 1'b0;
      o_data_sop     <= 1'b0;
      o_data_eop     <= 1'b0;
      o_re_num       <= '0;
      o_rbg_num      <= '0;
      o_rbg_load     <= 1'b0;
      o_symb_clr     <= 1'b0;
      o_symb_1st     <= 1'b0;
      o_aiu_idx      <= 1'b0;
      o_err_overrun  <= 1'b0;
      o_err_underrun <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_data_vld     <= vld_d;
      o_data_sop     <= sop_d;
      o_data_eop     <= eop_d;
      o_re_num       <= re_d;
      o_rbg_num      <= rbg_d;
      o_rbg_load     <= load_d;
      o_symb_clr     <= clr_d;
      o_symb_1st     <= s1st_d;
      o_aiu_idx      <= aiu_d;
      o_err_overrun  <= ovr_d;
      o_err_underrun <= und_d;
      o_busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_rbg_sched_ctrl.sv
// Bench for rbg_sched_ctrl: directed symbol sequences, a behavioural model
// checked on every cycle, and hand-computed totals per scenario.
module tb_rbg_sched_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_cfg_vld = 1'b0;
  logic [3:0] i_cfg_rbg_size = '0;
  logic [8:0] i_cfg_rb_total = '0;
  logic [3:0] i_cfg_pwr_symb = '0;
  logic       i_cfg_aiu_idx = 1'b0;
  logic       i_data_vld = 1'b0, i_data_sop = 1'b0, i_data_eop = 1'b0;
  logic [3:0] i_symb_idx = '0;
  logic       o_data_vld, o_data_sop, o_data_eop;
  logic [7:0] o_re_num, o_rbg_num;
  logic       o_rbg_load, o_symb_clr, o_symb_1st, o_aiu_idx;
  logic       o_err_overrun, o_err_underrun, o_busy;

  rbg_sched_ctrl #(.RE_PER_RB(12), .RBW(9)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cfg_vld(i_cfg_vld), .i_cfg_rbg_size(i_cfg_rbg_size),
    .i_cfg_rb_total(i_cfg_rb_total), .i_cfg_pwr_symb(i_cfg_pwr_symb),
    .i_cfg_aiu_idx(i_cfg_aiu_idx),
    .i_data_vld(i_data_vld), .i_data_sop(i_data_sop), .i_data_eop(i_data_eop),
    .i_symb_idx(i_symb_idx),
    .o_data_vld(o_data_vld), .o_data_sop(o_data_sop), .o_data_eop(o_data_eop),
    .o_re_num(o_re_num), .o_rbg_num(o_rbg_num), .o_rbg_load(o_rbg_load),
    .o_symb_clr(o_symb_clr), .o_symb_1st(o_symb_1st), .o_aiu_idx(o_aiu_idx),
    .o_err_overrun(o_err_overrun), .o_err_underrun(o_err_underrun),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_sh_size = 0, m_sh_rb = 0, m_sh_pwr = 0, m_sh_aiu = 0;
  bit m_cfgd = 0, m_in = 0, m_pwr = 0;
  int m_len = 12, m_tot = 12, m_n = 0, m_aiu = 0;
  int e_vld, e_sop, e_eop, e_re, e_rbg, e_load, e_clr, e_s1, e_aiu, e_ovr, e_und, e_busy;

  // running totals of DUT outputs, for the hand-computed checks
  int c_vld = 0, c_load = 0, c_ovr = 0, c_und = 0, c_clr = 0, c_s1 = 0;
  int c_eop = 0, c_und_eop = 0, c_last_re = 0, c_last_rbg = 0;

  always @(posedge i_clk) begin
    bit acc;
    acc = 0;
    e_vld = 0; e_sop = 0; e_eop = 0; e_re = 0; e_rbg = 0; e_load = 0;
    e_clr = 0; e_s1 = 0; e_ovr = 0; e_und = 0;
    if (i_reset) begin
      m_sh_size = 0; m_sh_rb = 0; m_sh_pwr = 0; m_sh_aiu = 0;
      m_cfgd = 0; m_in = 0; m_pwr = 0; m_aiu = 0; m_n = 0;
      e_aiu = 0; e_busy = 0;
    end else begin
      if (m_cfgd && i_data_vld && i_data_sop) begin
        if (m_in && m_n < m_tot) e_und = 1;
        m_len = ((m_sh_size == 0) ? 1 : m_sh_size) * 12;
        m_tot = ((m_sh_rb == 0) ? 1 : m_sh_rb) * 12;
        m_aiu = m_sh_aiu;
        m_pwr = (int'(i_symb_idx) == m_sh_pwr);
        m_n   = 0;
        acc   = 1;
        e_sop = 1;
        e_clr = (i_symb_idx == 4'd0);
        m_in  = !i_data_eop;
      end else if (m_in && i_data_vld) begin
        if (m_n >= m_tot) e_ovr = 1;
        else acc = 1;
        if (i_data_eop) m_in = 0;
      end
      if (acc) begin
        e_vld  = 1;
        e_re   = m_n % m_len;
        e_rbg  = (m_n / m_len) % 256;
        e_load = (m_n % m_len == 0) && (m_n < m_tot);
        e_s1   = m_pwr;
        if (i_data_eop) begin
          e_eop = 1;
          if (m_n + 1 < m_tot) e_und = 1;
        end
        m_n++;
      end
      e_aiu  = m_aiu;
      e_busy = m_in;
      if (i_cfg_vld) begin
        m_sh_size = i_cfg_rbg_size; m_sh_rb = i_cfg_rb_total;
        m_sh_pwr  = i_cfg_pwr_symb; m_sh_aiu = i_cfg_aiu_idx;
        m_cfgd    = 1;
      end
    end
    #1;
    chk("data_vld", o_data_vld, e_vld);
    chk("data_sop", o_data_sop, e_sop);
    chk("data_eop", o_data_eop, e_eop);
    chk("re_num",   o_re_num,   e_re);
    chk("rbg_num",  o_rbg_num,  e_rbg);
    chk("rbg_load", o_rbg_load, e_load);
    chk("symb_clr", o_symb_clr, e_clr);
    chk("symb_1st", o_symb_1st, e_s1);
    chk("aiu_idx",  o_aiu_idx,  e_aiu);
    chk("overrun",  o_err_overrun,  e_ovr);
    chk("underrun", o_err_underrun, e_und);
    chk("busy",     o_busy,     e_busy);
    c_vld  += o_data_vld;  c_load += o_rbg_load; c_ovr += o_err_overrun;
    c_und  += o_err_underrun; c_clr += o_symb_clr; c_s1 += o_symb_1st;
    c_eop  += o_data_eop;  c_und_eop += (o_err_underrun & o_data_eop);
    if (o_data_vld) begin c_last_re = o_re_num; c_last_rbg = o_rbg_num; end
  end

  // ---------------- stimulus ----------------
  bit pend_cfg = 0;

  task automatic cfg(input int sz, input int rb, input int pwr, input int aiu);
    i_cfg_rbg_size = 4'(sz); i_cfg_rb_total = 9'(rb);
    i_cfg_pwr_symb = 4'(pwr); i_cfg_aiu_idx = 1'(aiu);
    i_cfg_vld = 1'b1;
    @(negedge i_clk);
    i_cfg_vld = 1'b0;
  endtask

  // One symbol of nre REs; optional eop, optional idle cycle after each RE.
  // With pend_cfg set, i_cfg_vld is raised on the sop cycle.
  task automatic sym(input int idx, input int nre, input bit eop_en, input bit gap);
    for (int i = 0; i < nre; i++) begin
      i_data_vld = 1'b1;
      i_data_sop = (i == 0);
      i_data_eop = eop_en && (i == nre - 1);
      i_symb_idx = 4'(idx);
      if (i == 0 && pend_cfg) begin i_cfg_vld = 1'b1; pend_cfg = 0; end
      @(negedge i_clk);
      i_cfg_vld = 1'b0;
      if (gap) begin
        i_data_vld = 1'b0; i_data_sop = 1'b0; i_data_eop = 1'b0;
        @(negedge i_clk);
      end
    end
    i_data_vld = 1'b0; i_data_sop = 1'b0; i_data_eop = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    int b_vld, b_load, b_ovr, b_und, b_clr, b_s1, b_eop, b_ue;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    chk("reset_busy", o_busy, 0);
    chk("reset_vld", o_data_vld, 0);

    // Unconfigured: stream ignored
    b_vld = c_vld;
    sym(0, 12, 1, 0);
    chk("idle_no_vld", c_vld - b_vld, 0);

    // Nominal symbol: rbg_size=4, rb_total=10
    cfg(4, 10, 2, 1);
    b_vld = c_vld; b_load = c_load; b_ovr = c_ovr; b_und = c_und;
    sym(1, 120, 1, 0);
    chk("nom_vld", c_vld - b_vld, 120);
    chk("nom_loads", c_load - b_load, 3);
    chk("nom_last_re", c_last_re, 23);
    chk("nom_last_rbg", c_last_rbg, 2);
    chk("nom_no_err", (c_ovr - b_ovr) + (c_und - b_und), 0);

    // Slot flags: symbols 0..3, power symbol 2
    b_clr = c_clr; b_s1 = c_s1;
    for (int s = 0; s < 4; s++) sym(s, 120, 1, 0);
    chk("slot_clr", c_clr - b_clr, 1);
    chk("slot_1st", c_s1 - b_s1, 120);

    // Overrun: 125 REs
    b_vld = c_vld; b_ovr = c_ovr;
    sym(5, 125, 1, 0);
    chk("ovr_pulses", c_ovr - b_ovr, 5);
    chk("ovr_vld", c_vld - b_vld, 120);

    // Underrun: 100 REs
    b_und = c_und; b_eop = c_eop; b_ue = c_und_eop;
    sym(5, 100, 1, 0);
    chk("und_pulses", c_und - b_und, 1);
    chk("und_with_eop", c_und_eop - b_ue, 1);
    chk("und_eop", c_eop - b_eop, 1);

    // cfg_vld coincident with sop: old shadow on this symbol
    i_cfg_rbg_size = 4'd2; i_cfg_rb_total = 9'd10;
    i_cfg_pwr_symb = 4'd2; i_cfg_aiu_idx = 1'b0;
    pend_cfg = 1;
    b_load = c_load;
    sym(3, 120, 1, 0);
    chk("cfg_same_sym_loads", c_load - b_load, 3);
    b_load = c_load;
    sym(3, 120, 1, 0);
    chk("cfg_next_sym_loads", c_load - b_load, 5);
    chk("cfg_next_aiu", o_aiu_idx, 0);

    // Gapped, missing eop, then a sop at RE 60
    cfg(4, 10, 7, 1);
    b_load = c_load; b_und = c_und;
    sym(4, 60, 0, 1);
    chk("gap_loads", c_load - b_load, 2);
    chk("gap_last_re", c_last_re, 11);
    sym(4, 120, 1, 0);
    chk("gap_restart_und", c_und - b_und, 1);

    // Reset at RE 30
    i_data_vld = 1'b1;
    for (int i = 0; i < 30; i++) begin
      i_data_sop = (i == 0); i_symb_idx = 4'd1;
      @(negedge i_clk);
    end
    i_data_sop = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0; i_data_vld = 1'b0;
    chk("rst_mid_vld", o_data_vld, 0);
    chk("rst_mid_busy", o_busy, 0);
    b_vld = c_vld;
    sym(0, 12, 1, 0);
    chk("rst_needs_cfg", c_vld - b_vld, 0);

    // Zero config treated as 1: 12-RE symbol; single-RE symbol
    cfg(0, 0, 0, 0);
    b_load = c_load; b_ovr = c_ovr;
    sym(0, 13, 1, 0);
    chk("zero_cfg_loads", c_load - b_load, 1);
    chk("zero_cfg_ovr", c_ovr - b_ovr, 1);
    cfg(4, 10, 0, 0);
    b_load = c_load; b_und = c_und;
    sym(0, 1, 1, 0);
    chk("single_re_load", c_load - b_load, 1);
    chk("single_re_und", c_und - b_und, 1);
    chk("single_re_busy", o_busy, 0);

    repeat (3) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
